// File: rtl/range_fix_arbiter.sv
// Round-robin arbiter that time-shares one registered range-fixer unit among
// NUM_REQ requesters: grant, wait out the fixer latency, return a one-cycle ack.

module range_fix_arbiter_lane #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int IDX     = 0
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               win
);
  logic blocked;
  int   di;
  int   dj;

  // A lane wins when it requests and no requester sits closer to ptr in
  // circular order.
  always_comb begin
    blocked = 1'b0;
    dj      = 0;
    di      = (IDX + NUM_REQ - int'(ptr)) % NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      dj = (j + NUM_REQ - int'(ptr)) % NUM_REQ;
      if (req[j] && (dj < di)) blocked = 1'b1;
    end
    win = req[IDX] & ~blocked;
  end
endmodule

module range_fix_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int FIX_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*10-1:0] req_val,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    ack,
  output logic [6:0]            rsp_val,
  output logic [ID_W-1:0]       rsp_id,
  output logic [9:0]            fix_val,
  input  logic [6:0]            fix_adj,
  output logic                  busy
);
  localparam int LAT_W = (FIX_LAT < 1) ? 1 : $clog2(FIX_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                    state_q, state_d;
  logic [ID_W-1:0]           ptr_q, ptr_d;
  logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [NUM_REQ-1:0]        ack_q, ack_d;
  logic [6:0]                rsp_val_q, rsp_val_d;
  logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
  logic [9:0]                fix_val_q, fix_val_d;

  logic [NUM_REQ-1:0][9:0]   val_lane;
  logic [NUM_REQ-1:0]        win;
  logic [ID_W-1:0]           win_id;
  logic [9:0]                win_val;
  logic [ID_W-1:0]           ptr_nxt;

  assign val_lane = req_val;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    range_fix_arbiter_lane #(
      .NUM_REQ(NUM_REQ), .ID_W(ID_W), .IDX(g)
    ) u_lane (
      .req(req), .ptr(ptr_q), .win(win[g])
    );
  end

  always_comb begin
    win_id  = '0;
    win_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_id  = ID_W'(i);
        win_val = val_lane[i];
      end
    end
    // Explicit wrap so non-power-of-2 NUM_REQ never leaves ptr out of range.
    ptr_nxt = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lat_cnt_d = lat_cnt_q;
    gnt_d     = gnt_q;
    ack_d     = ack_q;
    rsp_val_d = rsp_val_q;
    rsp_id_d  = rsp_id_q;
    fix_val_d = fix_val_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          fix_val_d = win_val;
          gnt_d     = win;
          rsp_id_d  = win_id;
          lat_cnt_d = '0;
          ptr_d     = ptr_nxt;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q == LAT_W'(FIX_LAT)) begin
          rsp_val_d = fix_adj;
          ack_d     = gnt_q;
          state_d   = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      RESP: begin
        ack_d   = '0;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      lat_cnt_q <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      rsp_val_q <= '0;
      rsp_id_q  <= '0;
      fix_val_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lat_cnt_q <= lat_cnt_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      rsp_val_q <= rsp_val_d;
      rsp_id_q  <= rsp_id_d;
      fix_val_q <= fix_val_d;
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign rsp_val = rsp_val_q;
  assign rsp_id  = rsp_id_q;
  assign fix_val = fix_val_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_range_fix_arbiter.sv
// Scoreboard bench: stimulus pushes expected (id, value, result, gap) entries
// from a round-robin reference; a negedge monitor pops and compares on ack.

module tb_range_fix_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [39:0] req_val = '0;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  // Four-requester DUT with a single-register fixer.
  logic [3:0] gnt1, ack1;
  logic [6:0] rsp_val1, fix_adj1 = '0;
  logic [1:0] rsp_id1;
  logic [9:0] fix_val1;
  logic       busy1;

  // Three-requester DUT with a three-stage fixer.
  logic [2:0] gnt3, ack3;
  logic [6:0] rsp_val3, fix_adj3 = '0, s1_3 = '0, s2_3 = '0;
  logic [1:0] rsp_id3;
  logic [9:0] fix_val3;
  logic       busy3;

  range_fix_arbiter #(.NUM_REQ(4), .ID_W(2), .FIX_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_val(req_val), .gnt(gnt1), .ack(ack1),
    .rsp_val(rsp_val1), .rsp_id(rsp_id1), .fix_val(fix_val1), .fix_adj(fix_adj1),
    .busy(busy1));

  range_fix_arbiter #(.NUM_REQ(3), .ID_W(2), .FIX_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req[2:0]), .req_val(req_val[29:0]), .gnt(gnt3),
    .ack(ack3), .rsp_val(rsp_val3), .rsp_id(rsp_id3), .fix_val(fix_val3),
    .fix_adj(fix_adj3), .busy(busy3));

  // Range-fixer behaviour: positive values mod 100, negatives 99 - (|v| mod 100).
  function automatic int fix_ref(input logic signed [9:0] v);
    int x;
    x = int'(v);
    if (x >= 0) return x % 100;
    return 99 - ((-x) % 100);
  endfunction

  always @(posedge clk) fix_adj1 <= 7'(fix_ref(fix_val1));
  always @(posedge clk) begin
    s1_3     <= 7'(fix_ref(fix_val3));
    s2_3     <= s1_3;
    fix_adj3 <= s2_3;
  end

  logic [3:0] m_gnt, m_ack;
  logic [6:0] m_rsp_val;
  logic [1:0] m_rsp_id;
  logic [9:0] m_fix_val;
  logic       m_busy;
  assign m_gnt     = sel ? {1'b0, gnt3} : gnt1;
  assign m_ack     = sel ? {1'b0, ack3} : ack1;
  assign m_rsp_val = sel ? rsp_val3 : rsp_val1;
  assign m_rsp_id  = sel ? rsp_id3  : rsp_id1;
  assign m_fix_val = sel ? fix_val3 : fix_val1;
  assign m_busy    = sel ? busy3    : busy1;

  function automatic int nreq(); return sel ? 3 : 4; endfunction
  function automatic int lat();  return sel ? 3 : 1; endfunction

  typedef struct { int id; logic [9:0] val; int adj; int gap; } exp_t;
  exp_t sbq[$];
  int   n_cmp = 0, n_fail = 0;
  int   mptr = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Next requester in round-robin order from the model's pointer.
  function automatic int pick(input logic [3:0] live);
    for (int d = 0; d < nreq(); d++)
      if (live[(mptr + d) % nreq()]) return (mptr + d) % nreq();
    return -1;
  endfunction

  // Monitor
  initial begin
    int cyc, gnt_cyc, last_ack;
    logic [3:0] prev_gnt, prev_ack;
    logic [6:0] held;
    bit inv;
    exp_t e;
    cyc = 0; gnt_cyc = 0; last_ack = 0; prev_gnt = '0; prev_ack = '0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_gnt = '0; prev_ack = '0; held = '0;
      end else begin
        cyc++;
        inv = ($countones(m_gnt) <= 1) && ($countones(m_ack) <= 1) &&
              (m_busy == (m_gnt != 0)) && !(m_ack != 0 && prev_ack != 0) &&
              (m_ack != 0 || m_rsp_val == held);
        chk("invariant", int'(inv), 1);
        if (m_gnt != 0 && prev_gnt == 0) begin
          gnt_cyc = cyc;
          if (sbq.size() == 0) chk("unexpected_gnt", int'(m_gnt), 0);
          else begin
            chk("gnt_id", int'(m_gnt), 1 << sbq[0].id);
            chk("fix_val", int'(m_fix_val), int'(sbq[0].val));
          end
        end else if (m_gnt != 0 && m_ack == 0 && sbq.size() > 0) begin
          chk("fix_val_hold", int'(m_fix_val), int'(sbq[0].val));
        end
        if (m_ack != 0) begin
          if (sbq.size() == 0) chk("unexpected_ack", int'(m_ack), 0);
          else begin
            e = sbq.pop_front();
            chk("ack_id", int'(m_ack), 1 << e.id);
            chk("gnt_at_ack", int'(m_gnt), 1 << e.id);
            chk("rsp_id", int'(m_rsp_id), e.id);
            chk("rsp_val", int'(m_rsp_val), e.adj);
            chk("latency", cyc - gnt_cyc, lat() + 1);
            if (e.gap != 0) chk("ack_gap", cyc - last_ack, e.gap);
          end
          held = m_rsp_val;
          last_ack = cyc;
        end
        prev_gnt = m_gnt;
        prev_ack = m_ack;
      end
    end
  end

  // hold=0: each requester drops on its own ack; hold=1: all held for n acks.
  task automatic burst(input logic [3:0] mask, input logic [39:0] vals,
                       input bit hold, input int n);
    logic [3:0] live;
    exp_t e;
    int j, got, budget;
    live = mask;
    for (int k = 0; k < n; k++) begin
      j     = pick(live);
      e.id  = j;
      e.val = vals[10*j +: 10];
      e.adj = fix_ref(e.val);
      e.gap = (k == 0) ? 0 : lat() + 3;
      sbq.push_back(e);
      mptr = (j + 1) % nreq();
      if (!hold) live[j] = 1'b0;
    end
    @(negedge clk);
    req_val = vals;
    req     = mask;
    got     = 0;
    budget  = n * (lat() + 3) + 20;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (m_ack != 0) begin
        got++;
        if (hold) begin
          if (got == n) req = '0;
        end else req &= ~m_ack;
      end else if (!hold && m_gnt != 0) begin
        for (int i = 0; i < 4; i++)
          if (m_gnt[i]) req_val[10*i +: 10] = 10'($urandom());
      end
    end
    if (got < n) begin
      chk("ack_timeout", got, n);
      req = '0;
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_bursts(input int cnt, input int maxmask);
    logic [3:0]  mask;
    logic [39:0] v;
    bit          hold;
    for (int r = 0; r < cnt; r++) begin
      mask = 4'($urandom_range(1, maxmask));
      v    = {8'($urandom()), $urandom()};
      hold = 1'($urandom_range(0, 1));
      burst(mask, v, hold, hold ? $urandom_range(2, 6) : $countones(mask));
    end
  endtask

  initial begin
    logic [3:0] m;
    exp_t e;
    int t;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", int'(gnt1), 0);
    chk("rst_ack", int'(ack1), 0);
    chk("rst_rsp_val", int'(rsp_val1), 0);
    chk("rst_rsp_id", int'(rsp_id1), 0);
    chk("rst_fix_val", int'(fix_val1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_busy3", int'(busy3), 0);
    rst = 1'b0;

    // All four at once: order 0,1,2,3, results 42,98,0,11, 4 cycles apart.
    burst(4'b1111, {10'd511, 10'd100, 10'h3FF, 10'd42}, 1'b0, 4);
    // Single request 150 -> 50.
    burst(4'b0001, {30'd0, 10'd150}, 1'b0, 1);
    // -100 -> 99; value scrambled while in flight.
    burst(4'b0010, {20'd0, 10'h39C, 10'd0}, 1'b0, 1);
    // Requesters 0 and 2 held continuously: strict alternation.
    burst(4'b0101, {10'd0, 10'd77, 10'd0, 10'h3F0}, 1'b1, 8);

    // Reset in WAIT discards the transaction and returns ptr to 0.
    m = 4'b0001;
    e.id = pick(m); e.val = 10'd321; e.adj = fix_ref(e.val); e.gap = 0;
    sbq.push_back(e);
    @(negedge clk);
    req_val = {30'd0, 10'd321};
    req = m;
    t = 0;
    while (m_gnt == 0 && t < 10) begin @(negedge clk); t++; end
    chk("rst_mid_granted", int'(m_gnt != 0), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_gnt", int'(gnt1), 0);
    chk("rst_mid_ack", int'(ack1), 0);
    chk("rst_mid_fix_val", int'(fix_val1), 0);
    chk("rst_mid_busy", int'(busy1), 0);
    sbq.delete();
    mptr = 0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    burst(4'b0100, {10'd0, 10'd250, 20'd0}, 1'b0, 1);

    rand_bursts(12, 15);

    // Switch to the three-requester, FIX_LAT=3 instance.
    rst = 1'b1;
    @(negedge clk);
    sel = 1'b1;
    sbq.delete();
    mptr = 0;
    @(negedge clk);
    rst = 1'b0;
    burst(4'b0011, {20'd0, 10'd37, 10'h3FF}, 1'b1, 4);
    burst(4'b0101, {10'd0, 10'd199, 10'd0, 10'd5}, 1'b1, 6);
    rand_bursts(8, 7);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/range_fix_arbiter.md
Name: range_fix_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered range-fixer unit among NUM_REQ requesters.
- The range-fixer wraps a signed 10-bit value into 0..99 and has a registered 7-bit output.
- Each granted requester's value is driven to the fixer, the fixer latency is waited out, and the adjusted result is returned with a one-cycle ack.
- Sits between the counter/score producers and the single shared fixer instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.
- FIX_LAT, 1, clock edges from fix_val being driven until fix_adj is valid (the fixer is a single posedge register, so 1).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_val  in  NUM_REQ*10  flattened signed values; requester i occupies bits [10*i+9:10*i].
- gnt  out  NUM_REQ  one-hot grant, high for the whole transaction.
- ack  out  NUM_REQ  one-hot, single-cycle result-valid pulse.
- rsp_val  out  7  adjusted result (0..99), valid while ack is high, held afterwards.
- rsp_id  out  ID_W  index of the requester that owns rsp_val.
- fix_val  out  10  signed value driven to the fixer's nf_val.
- fix_adj  in  7  fixer's adj_val output.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, ptr=0, lat_cnt=0.
  - gnt=0, ack=0, rsp_val=0, rsp_id=0, fix_val=0, busy=0.
  - Any in-flight transaction is discarded; no ack is issued for it.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req != 0, select the first i with req[i]=1, searching ptr, ptr+1, … modulo NUM_REQ.
  - At that edge (E0): fix_val <= req_val slice i, gnt <= onehot(i), rsp_id <= i, lat_cnt <= 0, ptr <= (i+1) mod NUM_REQ, state <= WAIT.
  - If req == 0, remain in IDLE with all outputs held.
- WAIT:
  - fix_val and gnt are held constant.
  - At each edge: if lat_cnt == FIX_LAT, then rsp_val <= fix_adj, ack <= onehot(i), state <= RESP.
  - Otherwise lat_cnt <= lat_cnt+1.
  - With FIX_LAT=1 the capture happens at edge E2.
- RESP:
  - ack is high for exactly this one cycle.
  - At the next edge: ack <= 0, gnt <= 0, state <= IDLE.
  - req is not sampled in RESP, so a registered requester may drop req on the edge that ends RESP without being re-served.
- Latency and throughput:
  - ack is high from edge E(FIX_LAT+1) to E(FIX_LAT+2).
  - One transaction completes every FIX_LAT+3 cycles.
- Value capture: req_val is sampled only at the grant edge. Later changes to req_val, or req dropping mid-transaction, do not abort the transaction; ack still pulses.
- Re-request: if req[i] is still high when IDLE is re-entered, it is a new transaction. Round-robin ensures every other active requester is served first.
- Width rules:
  - fix_val is passed through unchanged (signed range -512..511).
  - rsp_val is fix_adj unmodified; no arithmetic is done in this block.
  - ptr wraps modulo NUM_REQ, including non-power-of-2 values.
- Outputs are registered: gnt and ack are never asserted for more than one requester at a time.

Test Plan:
1. Single request: req=0001, val0=150. Required: gnt=0001 and fix_val=150 after E0; ack=0001 for one cycle after E2; rsp_val=50, rsp_id=0; busy low again after E3.
2. Simultaneous requests: all four req high, vals 42, -1, 100, 511, each dropped on its ack. Required: service order 0,1,2,3; results 42, 98, 0, 11; acks exactly 4 cycles apart; never two grant bits high at once.
3. Fairness: req0 and req2 held high continuously. Required: grants alternate 0, 2, 0, 2 for at least 8 transactions; ptr advances correctly past unused indices.
4. Stale value: req1 with val -100, changed to 5 during WAIT. Required: fix_val stays -100; rsp_val=99 with rsp_id=1.
5. Reset mid-operation: assert rst in WAIT. Required: gnt, ack, fix_val and busy go to 0 before the next edge. After release with req=0100, requester 2 is granted (ptr reset to 0 and searched forward); no ack is issued for the aborted transaction.
6. Longer fixer latency: FIX_LAT=3 with a 3-stage delayed fixer model, val=-1. Required: ack after E4, rsp_val=98; throughput of 6 cycles per transaction under continuous requests.
